// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, 2-entry decode queue, next_pc select.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  count;
    logic [1:0]  count_pop;
    logic [31:0] req_pc;
    logic [31:0] q_inst [2];
    logic [31:0] q_pc   [2];
    logic        fault_q;
    logic        misaligned;
    logic        grant;
    logic        push;
    logic        pop;

`ifdef FETCH_MISALIGN_CHK_EN
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (misaligned) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
    assign fault_q    = 1'b0;
`endif

    assign fetch_fault = fault_q;
    assign inst_valid  = (count != 2'd0);
    assign inst        = q_inst[0];
    assign inst_pc     = q_pc[0];
    assign pop         = inst_valid && inst_ready;
    assign count_pop   = count - {1'b0, pop};
    // A same-cycle pop frees a slot, so the throttle looks at the post-pop occupancy.
    assign imem_req    = (state == S_REQ) && (count_pop != 2'd2) && !fault_q;
    assign imem_addr   = pc;
    assign grant       = imem_req && imem_gnt;
    assign push        = (state == S_WAIT) && imem_rvalid && !redirect;

    always_comb begin
        next_pc = pc;
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect) begin
            next_pc = misaligned ? pc : redirect_pc;
        end else if (grant) begin
            next_pc = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (grant) begin
                        req_pc <= pc;
                        state  <= redirect ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response landing in the redirect cycle is consumed and discarded here.
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end else if (redirect) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            q_inst[0] <= '0;
            q_inst[1] <= '0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
        end else if (redirect) begin
            count <= '0;
        end else begin
            if (pop) begin
                q_inst[0] <= q_inst[1];
                q_pc[0]   <= q_pc[1];
            end
            if (push) begin
                if (count_pop == 2'd0) begin
                    q_inst[0] <= imem_rdata;
                    q_pc[0]   <= req_pc;
                end else begin
                    q_inst[1] <= imem_rdata;
                    q_pc[1]   <= req_pc;
                end
            end
            count <= count_pop + {1'b0, push};
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register and a single-outstanding memory model.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    int          checks;
    int          failures;
    int          gcount;
    int          lat;
    int          cnt;
    logic        pend;
    logic [31:0] paddr;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: PC register update, then memory model retire/accept and drive of the response.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        logic [31:0] npc;
        g   = (imem_req === 1'b1) && imem_gnt;
        a   = imem_addr;
        npc = next_pc;
        @(posedge clk);
        #1;
        pc = npc;
        if (g) gcount++;
        if (imem_rvalid) pend = 1'b0;
        else if (pend && cnt > 0) cnt--;
        if (g) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = a;
        end
        imem_rvalid = pend && (cnt == 0);
        imem_rdata  = pend ? (paddr ^ 32'hDEAD_0000) : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        gcount      = 0;
        lat         = 1;
        cnt         = 0;
        pend        = 1'b0;
        paddr       = '0;
        pc          = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b1;

        // Reset values, and reset outranks redirect on next_pc
        reset = 1'b1;
        tick();
        tick();
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        settle();
        check("rst_over_redirect", next_pc, 32'h0);
        redirect = 1'b0;
        reset    = 1'b0;
        settle();
        check("idle_no_req", {31'b0, imem_req}, 32'h0);

        // Zero-wait streaming: one instruction every two cycles
        tick();
        for (int k = 0; k < 4; k++) begin
            check("stream_req", {31'b0, imem_req}, 32'h1);
            check("stream_addr", imem_addr, 32'(4 * k));
            check("stream_next_pc_adv", next_pc, 32'(4 * k + 4));
            check("stream_valid_req", {31'b0, inst_valid}, (k > 0) ? 32'h1 : 32'h0);
            if (k > 0) check("stream_inst_pc", inst_pc, 32'(4 * (k - 1)));
            tick();
            check("stream_wait_req", {31'b0, imem_req}, 32'h0);
            check("stream_wait_valid", {31'b0, inst_valid}, 32'h0);
            check("stream_next_pc_hold", next_pc, 32'(4 * k + 4));
            tick();
        end
        check("stream_last_pc", inst_pc, 32'hC);
        check("stream_last_inst", inst, 32'hDEAD_000C);

        // Decode stall: queue fills after two grants, then drains in order
        do_reset();
        inst_ready = 1'b0;
        tick();
        gcount = 0;
        for (int i = 0; i < 10; i++) tick();
        check("stall_grants", 32'(gcount), 32'd2);
        check("stall_req", {31'b0, imem_req}, 32'h0);
        check("stall_next_pc", next_pc, 32'h8);
        check("stall_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        settle();
        check("release_head_inst", inst, 32'hDEAD_0000);
        check("release_req", {31'b0, imem_req}, 32'h1);
        tick();
        check("release_2nd_valid", {31'b0, inst_valid}, 32'h1);
        check("release_2nd_pc", inst_pc, 32'h4);
        tick();
        check("release_3rd_pc", inst_pc, 32'h8);

        // Redirect during WAIT with 3-cycle memory latency
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        settle();
        check("rdw_next_pc", next_pc, 32'h100);
        tick();
        redirect = 1'b0;
        settle();
        check("rdw_drop_req", {31'b0, imem_req}, 32'h0);
        check("rdw_flushed", {31'b0, inst_valid}, 32'h0);
        tick();
        check("rdw_drop_rsp_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("rdw_stale_gone", {31'b0, inst_valid}, 32'h0);
        check("rdw_req", {31'b0, imem_req}, 32'h1);
        check("rdw_addr", imem_addr, 32'h100);
        for (int i = 0; i < 4; i++) tick();
        check("rdw_valid", {31'b0, inst_valid}, 32'h1);
        check("rdw_inst_pc", inst_pc, 32'h100);
        check("rdw_inst", inst, 32'hDEAD_0100);
        lat = 1;

        // Redirect coinciding with a grant at pc=8
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        settle();
        check("rdg_addr", imem_addr, 32'h8);
        check("rdg_req", {31'b0, imem_req}, 32'h1);
        check("rdg_next_pc", next_pc, 32'h200);
        tick();
        redirect = 1'b0;
        settle();
        check("rdg_flushed", {31'b0, inst_valid}, 32'h0);
        check("rdg_drop_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("rdg_no_stale", {31'b0, inst_valid}, 32'h0);
        check("rdg_addr_new", imem_addr, 32'h200);
        tick();
        tick();
        check("rdg_inst_pc", inst_pc, 32'h200);

        // PC wrap at the top of the address space
        do_reset();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        check("wrap_redirect", next_pc, 32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_next_pc", next_pc, 32'h0);
        check("wrap_no_stale", {31'b0, inst_valid}, 32'h0);
        tick();
        tick();
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst", inst, 32'h2152_FFFC);

        // Misaligned redirect
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        settle();
`ifdef FETCH_MISALIGN_CHK_EN
        check("mis_next_pc_hold", next_pc, 32'h0);
        tick();
        redirect = 1'b0;
        settle();
        check("mis_fault", {31'b0, fetch_fault}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("mis_req_blocked", {31'b0, imem_req}, 32'h0);
            tick();
        end
        do_reset();
        check("mis_fault_cleared", {31'b0, fetch_fault}, 32'h0);
        tick();
        check("mis_req_resumed", {31'b0, imem_req}, 32'h1);
`else
        check("mis_next_pc", next_pc, 32'h102);
        tick();
        redirect = 1'b0;
        settle();
        check("mis_no_fault", {31'b0, fetch_fault}, 32'h0);
        check("mis_req", {31'b0, imem_req}, 32'h1);
        check("mis_addr", imem_addr, 32'h102);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
